sub_bytes_seq: RTL

Parametrised, sequential AES SubBytes/InvSubBytes engine. It accepts one 128-bit state over a valid/ready handshake. It substitutes `LANES` bytes per clock through a shared bank of dual-mode S-boxes, then presents the result over a second valid/ready handshake. It sits between the key-add and shift-rows stages of both the encryption and decryption datapaths, trading area against latency through `LANES`.

---
 rtl/aes_pkg.sv | 21 ++
 rtl/sbox_dual.sv | 63 ++++++
 rtl/sub_bytes_seq.sv | 117 +++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions: state geometry, stage FSM encoding and byte access.
package aes_pkg;

    localparam int unsigned AES_STATE_W = 128;
    localparam int unsigned AES_BYTES   = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } aes_fsm_e;

    // Byte k of a state, byte 0 being the most significant.
    function automatic logic [7:0] get_byte(input logic [AES_STATE_W-1:0] state,
                                            input int unsigned            k);
        logic [AES_STATE_W-1:0] shifted;
        shifted = state << (8 * k);
        return shifted[AES_STATE_W-1 -: 8];
    endfunction

endpackage

// File: rtl/sbox_dual.sv
// Combinational AES S-box, forward or inverse selected by inverse_i.
// Built from the GF(2^8) inverse plus the affine map rather than two ROM tables,
// so one field inverter is shared by both directions.
module sbox_dual (
    input  logic [7:0] data_i,
    input  logic       inverse_i,
    output logic [7:0] data_o
);

    // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                p = p ^ x;
            end
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // x^254 == x^-1 for x != 0, and maps 0 to 0 as AES requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] p;
        logic [7:0] sq;
        p  = 8'h01;
        sq = a;
        for (int i = 1; i < 8; i++) begin
            sq = gf_mul(sq, sq);
            p  = gf_mul(p, sq);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int unsigned n);
        logic [15:0] dbl;
        dbl = {b, b} << n;
        return dbl[15:8];
    endfunction

    logic [7:0] fwd_out;
    logic [7:0] inv_affine;
    logic [7:0] inv_out;

    // Forward: field inverse, then affine map with constant 0x63.
    always_comb begin
        logic [7:0] t;
        t       = gf_inv(data_i);
        fwd_out = t ^ rotl8(t, 1) ^ rotl8(t, 2) ^ rotl8(t, 3) ^ rotl8(t, 4) ^ 8'h63;
    end

    // Inverse: undo the affine map, then field inverse.
    always_comb begin
        inv_affine = rotl8(data_i, 1) ^ rotl8(data_i, 3) ^ rotl8(data_i, 6) ^ 8'h05;
        inv_out    = gf_inv(inv_affine);
    end

    assign data_o = inverse_i ? inv_out : fwd_out;

endmodule

// File: rtl/sub_bytes_seq.sv
// Sequential SubBytes/InvSubBytes: LANES bytes of a 128-bit state per cycle through
// a shared bank of dual-mode S-boxes, with valid/ready on both sides.
module sub_bytes_seq
    import aes_pkg::*;
#(
    parameter int unsigned LANES = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_valid,
    output logic                   o_ready,
    input  logic [AES_STATE_W-1:0] i_state,
    input  logic                   i_inverse,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic [AES_STATE_W-1:0] o_state,
    output logic                   o_busy
);

    localparam int unsigned N      = AES_BYTES / LANES;
    localparam int unsigned CNT_W  = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16))
    begin : g_bad_lanes
        $error("sub_bytes_seq: LANES must be one of 1, 2, 4, 8, 16");
    end

    aes_fsm_e               state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   mode_q, mode_d;
    logic [AES_STATE_W-1:0] work_q, work_d;

    logic [7:0]             sbox_in  [LANES];
    logic [7:0]             sbox_out [LANES];
    logic [AES_BYTES-1:0]   we;
    logic [AES_STATE_W-1:0] run_next;

    // Group mux and S-box bank: lane l handles byte cnt*LANES + l.
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign sbox_in[l] = get_byte(work_q, 32'(cnt_q) * LANES + 32'(l));

        sbox_dual u_sbox (
            .data_i    (sbox_in[l]),
            .inverse_i (mode_q),
            .data_o    (sbox_out[l])
        );
    end

    // Write-enable decode: only bytes of the active group take the S-box result.
    for (genvar b = 0; b < AES_BYTES; b++) begin : g_byte
        localparam int unsigned HI   = AES_STATE_W - 1 - 8 * b;
        localparam int unsigned LANE = b % LANES;
        localparam int unsigned GRP  = b / LANES;

        assign we[b]             = (state_q == RUN) && (cnt_q == CNT_W'(GRP));
        assign run_next[HI -: 8] = we[b] ? sbox_out[LANE] : work_q[HI -: 8];
    end

    // Next-state logic: accept in IDLE, substitute one group per cycle in RUN, hold in DONE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        work_d  = work_q;
        unique case (state_q)
            IDLE: begin
                if (i_valid) begin
                    state_d = RUN;
                    work_d  = i_state;
                    mode_d  = i_inverse;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                work_d = run_next;
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                if (i_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers; reset clears any block in flight.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
            work_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            work_q  <= work_d;
        end
    end

    // Handshake outputs decode registered state only.
    always_comb begin
        o_ready = (state_q == IDLE);
        o_valid = (state_q == DONE);
        o_busy  = (state_q == RUN) || (state_q == DONE);
        o_state = work_q;
    end

endmodule
